// File: rtl/apb_exit_status.sv
// apb_exit_status: APB exit-status responder.
// Software writes its final status code to EXIT; the block latches it once and
// presents done_o/status_o to the bench until reset.
// Optional watchdog guarded by the EXIT_WATCHDOG_EN macro: when defined, a
// free-running counter forces an ERROR exit if software never reports.
//
// Register map (PADDR[3:2]):
//   0x0 EXIT       W  (reads return status_o)
//   0x4 INFO       R  bit0 = done_o, bit1 = timeout_o
//   0x8 WDOG_LIMIT RW (reads 0 without the watchdog)
//   0xC WDOG_COUNT R  (reads 0 without the watchdog)
module apb_exit_status #(
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      done_o,
    output logic [31:0]               status_o,
    output logic                      timeout_o
);

    localparam logic [31:0] CODE_SUCCESS = 32'h0000_0000;
    localparam logic [31:0] CODE_FAIL    = 32'h0000_0001;
    localparam logic [31:0] CODE_ERROR   = 32'hFFFF_FFFF;

    localparam logic [1:0] SEL_EXIT  = 2'd0;
    localparam logic [1:0] SEL_INFO  = 2'd1;
    localparam logic [1:0] SEL_LIMIT = 2'd2;
    localparam logic [1:0] SEL_COUNT = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_status;

    logic [1:0]  w_sel;
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_in_run;
    logic        w_exit_wr;
    logic [31:0] w_exit_code;
    logic        w_unused;

    // Watchdog-facing signals shared by both build variants
    logic        w_expire;
    logic        w_limit_err;
    logic [31:0] w_wdog_limit;
    logic [31:0] w_wdog_count;
    logic        w_timeout;

    assign w_sel    = PADDR[3:2];
    assign w_access = PSEL & PENABLE;
    assign w_wr     = w_access & PWRITE;
    assign w_rd     = w_access & ~PWRITE;
    assign w_in_run = (r_state == ST_RUN);

    // Only PADDR[3:2] is decoded; the remaining address bits are don't-care
    assign w_unused = ^{PADDR[APB_ADDR_WIDTH-1:4], PADDR[1:0]};

    // An EXIT write is only accepted while no report has been latched yet
    assign w_exit_wr = w_wr & (w_sel == SEL_EXIT) & w_in_run;

    // Map the written value onto the three legal exit codes
    always_comb begin
        w_exit_code = CODE_ERROR;
        if (PWDATA == 32'd0) begin
            w_exit_code = CODE_SUCCESS;
        end else if (PWDATA == 32'd1) begin
            w_exit_code = CODE_FAIL;
        end
    end

`ifdef EXIT_WATCHDOG_EN
    logic [31:0] r_wdog_limit;
    logic [31:0] r_wdog_count;
    logic        r_timeout;
    logic        w_limit_wr;

    assign w_limit_wr = w_wr & (w_sel == SEL_LIMIT) & w_in_run;

    // Expiry is suppressed by a same-edge EXIT write (handled in the FSM) and by
    // a same-edge limit reload, which restarts the count from zero.
    assign w_expire = w_in_run & (r_wdog_limit != '0) & ~w_limit_wr &
                      (r_wdog_count == (r_wdog_limit - 32'd1));

    // Limit register and run-time counter; both freeze once DONE is reached
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wdog_limit <= '0;
            r_wdog_count <= '0;
        end else if (w_in_run) begin
            if (w_limit_wr) begin
                r_wdog_limit <= PWDATA;
                r_wdog_count <= '0;
            end else if (r_wdog_limit != '0) begin
                r_wdog_count <= r_wdog_count + 32'd1;
            end else begin
                r_wdog_count <= '0;
            end
        end
    end

    // Timeout flag records whether DONE was forced by the watchdog
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_timeout <= 1'b0;
        end else if (w_in_run && !w_exit_wr && w_expire) begin
            r_timeout <= 1'b1;
        end
    end

    assign w_limit_err  = ~w_in_run;
    assign w_wdog_limit = r_wdog_limit;
    assign w_wdog_count = r_wdog_count;
    assign w_timeout    = r_timeout;
`else
    assign w_expire     = 1'b0;
    assign w_limit_err  = 1'b0;
    assign w_wdog_limit = '0;
    assign w_wdog_count = '0;
    assign w_timeout    = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: RUN leaves on an EXIT write or watchdog expiry; DONE is absorbing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_exit_wr || w_expire) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Status latches on the same edge as the RUN->DONE transition; EXIT beats expiry
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_status <= CODE_ERROR;
        end else if (w_in_run) begin
            if (w_exit_wr) begin
                r_status <= w_exit_code;
            end else if (w_expire) begin
                r_status <= CODE_ERROR;
            end
        end
    end

    // Combinational read mux, driven only during a read access phase
    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (w_sel)
                SEL_EXIT:  PRDATA = r_status;
                SEL_INFO:  PRDATA = {30'd0, w_timeout, ~w_in_run};
                SEL_LIMIT: PRDATA = w_wdog_limit;
                SEL_COUNT: PRDATA = w_wdog_count;
                default:   PRDATA = '0;
            endcase
        end
    end

    // Error response for writes to read-only registers and late reports
    always_comb begin
        PSLVERR = 1'b0;
        if (w_wr) begin
            case (w_sel)
                SEL_EXIT:  PSLVERR = ~w_in_run;
                SEL_INFO:  PSLVERR = 1'b1;
                SEL_LIMIT: PSLVERR = w_limit_err;
                SEL_COUNT: PSLVERR = 1'b1;
                default:   PSLVERR = 1'b0;
            endcase
        end
    end

    assign PREADY    = 1'b1;
    assign done_o    = ~w_in_run;
    assign status_o  = r_status;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_apb_exit_status.sv
// Testbench for apb_exit_status: directed steps plus randomized traffic checked
// against a cycle-count based reference model. Watchdog steps are built only
// when EXIT_WATCHDOG_EN is defined.
module tb_apb_exit_status;

`ifdef EXIT_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        done_o;
    logic [31:0] status_o;
    logic        timeout_o;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model: exit record plus watchdog expressed as absolute cycle numbers
    logic        m_done;
    logic [31:0] m_status;
    logic        m_timeout;
    longint      m_limit;
    longint      m_wcyc;
    longint      m_frozen;

    apb_exit_status #(.APB_ADDR_WIDTH(12)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .done_o   (done_o),
        .status_o (status_o),
        .timeout_o(timeout_o)
    );

    always #5 HCLK = ~HCLK;

    // Edge counter used as the model's notion of time
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] map_code(input logic [31:0] v);
        if (v == 32'd0) return 32'd0;
        if (v == 32'd1) return 32'd1;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        m_done    = 1'b0;
        m_status  = 32'hFFFF_FFFF;
        m_timeout = 1'b0;
        m_limit   = 0;
        m_wcyc    = 0;
        m_frozen  = 0;
    endtask

    // Watchdog fires on the edge numbered write_edge + limit
    task automatic model_sync(input int c);
        if (!m_done && m_limit != 0 && longint'(c) >= m_wcyc + m_limit) begin
            m_done    = 1'b1;
            m_status  = 32'hFFFF_FFFF;
            m_timeout = 1'b1;
            m_frozen  = m_limit;
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_done"},    {31'd0, done_o},    {31'd0, m_done});
        chk({tag, "_status"},  status_o,           m_status);
        chk({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, m_timeout});
    endtask

    // One APB transfer starting at a negedge; checks response and resulting outputs
    task automatic apb(input logic [11:0] addr, input logic wr, input logic [31:0] data);
        logic [1:0]  sel;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          c;
        sel     = addr[3:2];
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = data;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        #1;
        chk("setup_pslverr", {31'd0, PSLVERR}, 32'd0);
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1;
        c = cyc;
        model_sync(c);
        exp_err = 1'b0;
        exp_rd  = 32'd0;
        case (sel)
            2'd0: begin exp_rd = m_status; exp_err = m_done; end
            2'd1: begin exp_rd = {30'd0, m_timeout, m_done}; exp_err = 1'b1; end
            2'd2: begin exp_rd = WDOG ? m_limit[31:0] : 32'd0; exp_err = WDOG & m_done; end
            default: begin
                if (!WDOG || (!m_done && m_limit == 0)) exp_rd = 32'd0;
                else if (m_done) exp_rd = m_frozen[31:0];
                else exp_rd = 32'(longint'(c) - m_wcyc);
                exp_err = 1'b1;
            end
        endcase
        if (!wr) exp_err = 1'b0;
        chk("pready", {31'd0, PREADY}, 32'd1);
        chk(wr ? "wr_pslverr" : "rd_pslverr", {31'd0, PSLVERR}, {31'd0, exp_err});
        if (!wr) chk($sformatf("rdata_%0d", sel), PRDATA, exp_rd);
        if (wr && !exp_err) begin
            if (sel == 2'd0) begin
                m_done    = 1'b1;
                m_status  = map_code(data);
                m_timeout = 1'b0;
                m_frozen  = (m_limit == 0) ? 0 : longint'(c) + 1 - m_wcyc;
            end else if (sel == 2'd2 && WDOG) begin
                m_limit = longint'(data);
                m_wcyc  = longint'(c) + 1;
            end
        end
        @(negedge HCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        model_sync(cyc);
        chk_outputs("post_xfer");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge HCLK);
            model_sync(cyc);
            chk_outputs("idle");
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        model_reset();
        chk_outputs("reset");
    endtask

    function automatic logic [11:0] rand_addr(input logic [1:0] sel);
        logic [11:0] a;
        a = 12'($urandom) & 12'hFF3;
        return a | {8'd0, sel, 2'b00};
    endfunction

    initial begin
        logic [31:0] code;
        int          rise;
        model_reset();
        @(negedge HCLK);
        do_reset();
        chk("rst_pready", {31'd0, PREADY}, 32'd1);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        apb(12'h004, 1'b0, 32'd0);
        apb(12'h000, 1'b0, 32'd0);
        apb(12'h008, 1'b0, 32'd0);
        apb(12'h00C, 1'b0, 32'd0);

        // First report wins; later EXIT writes error out
        apb(12'h000, 1'b1, 32'd0);
        chk("exit0_status", status_o, 32'd0);
        apb(12'h000, 1'b1, 32'd1);
        apb(12'h000, 1'b0, 32'd0);
        chk("exit0_kept", status_o, 32'd0);

        // Non 0/1 value maps to ERROR; read-only write errors
        do_reset();
        apb(12'h000, 1'b1, 32'h2A);
        chk("exit2a_status", status_o, 32'hFFFF_FFFF);
        apb(12'h00C, 1'b1, 32'h5);
        apb(12'h004, 1'b1, 32'h5);
        apb(12'h004, 1'b0, 32'd0);

        // Randomized sessions, watchdog limits included when configured
        for (int i = 0; i < 16; i++) begin
            do_reset();
            apb(rand_addr(2'($urandom_range(0, 3))), 1'b0, 32'd0);
            apb(rand_addr(2'($urandom_range(0, 1) * 2 + 1)), 1'b1, $urandom);
            if ($urandom_range(0, 1) == 1) apb(rand_addr(2'd2), 1'b1, 32'($urandom_range(3, 30)));
            idle($urandom_range(0, 5));
            apb(rand_addr(2'd3), 1'b0, 32'd0);
            case ($urandom_range(0, 2))
                0: code = 32'd0;
                1: code = 32'd1;
                default: code = $urandom;
            endcase
            apb(rand_addr(2'd0), 1'b1, code);
            apb(rand_addr(2'd0), 1'b1, $urandom);
            apb(rand_addr(2'd2), 1'b1, 32'($urandom_range(1, 9)));
            for (int s = 0; s < 4; s++) apb(rand_addr(2'(s)), 1'b0, 32'd0);
        end

`ifdef EXIT_WATCHDOG_EN
        // Watchdog expiry exactly LIMIT edges after the limit write edge
        do_reset();
        apb(12'h008, 1'b1, 32'd10);
        rise = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge HCLK);
            model_sync(cyc);
            chk_outputs("wd_idle");
            if (done_o === 1'b1 && rise < 0) rise = int'(longint'(cyc) - m_wcyc);
        end
        chk("wd_rise_cycles", 32'(rise), 32'd10);
        chk("wd_timeout", {31'd0, timeout_o}, 32'd1);
        apb(12'h004, 1'b0, 32'd0);
        apb(12'h00C, 1'b0, 32'd0);

        // EXIT access ending on the expiry edge beats the watchdog
        do_reset();
        apb(12'h008, 1'b1, 32'd5);
        for (int k = 0; k < 20 && longint'(cyc) < m_wcyc + 3; k++) @(negedge HCLK);
        apb(12'h000, 1'b1, 32'd1);
        chk("race_status", status_o, 32'd1);
        chk("race_timeout", {31'd0, timeout_o}, 32'd0);

        // Rewriting the limit mid-count restarts the count
        do_reset();
        apb(12'h008, 1'b1, 32'd20);
        idle(4);
        apb(12'h00C, 1'b0, 32'd0);
        apb(12'h008, 1'b1, 32'd30);
        apb(12'h00C, 1'b0, 32'd0);
        apb(12'h008, 1'b0, 32'd0);
`endif

        // Asynchronous reset while DONE, then a fresh report is accepted
        do_reset();
        apb(12'h000, 1'b1, 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        chk_outputs("async_rst");
        chk("async_rst_prdata", PRDATA, 32'd0);
        chk("async_rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("async_rst_pready", {31'd0, PREADY}, 32'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        apb(12'h000, 1'b1, 32'd1);
        chk("after_rst_status", status_o, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
